rst_seq_ctrl: RTL and testbench

RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

---
 rtl/rst_seq_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_rst_seq_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: holds every domain in reset, then releases the domains one
// at a time, waiting for each to acknowledge (or time out) before the next.
// All outputs are registered from the current FSM state, so each output
// changes one cycle after the state transition that selects it.
module rst_seq_ctrl #(
   parameter int NUM_DOMAINS = 4,
   parameter int HOLD_CYCLES = 16,
   parameter int GAP_CYCLES  = 8,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic                   clk,
   input  logic                   rst_async,
   input  logic                   ext_rst_n,
   input  logic                   sw_rst_req,
   input  logic [NUM_DOMAINS-1:0] dom_rst_ack,
   output logic [NUM_DOMAINS-1:0] dom_rst_async,
   output logic [NUM_DOMAINS-1:0] dom_deassert,
   output logic                   all_ready,
   output logic                   seq_error
);

   localparam int              IW       = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
   localparam logic [7:0]      HOLD_LD  = 8'(HOLD_CYCLES - 1);
   localparam logic [7:0]      GAP_LD   = 8'(GAP_CYCLES - 1);
   localparam logic [7:0]      TMO_LD   = 8'(ACK_TIMEOUT);
   localparam logic [IW-1:0]   LAST_IDX = IW'(NUM_DOMAINS - 1);

   typedef enum logic [2:0] {
      ST_ASSERT  = 3'd0,
      ST_RELEASE = 3'd1,
      ST_WAITACK = 3'd2,
      ST_GAP     = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   // Synchronizer bank: bit NUM_DOMAINS carries ext_rst_n, the rest carry acks.
   logic [NUM_DOMAINS:0]   r_sync1;
   logic [NUM_DOMAINS:0]   r_sync2;

   state_t                 r_state;
   state_t                 w_nxt_state;
   logic [7:0]             r_cnt;
   logic [7:0]             w_nxt_cnt;
   logic [IW-1:0]          r_idx;
   logic [IW-1:0]          w_nxt_idx;
   logic                   w_set_err;

   logic [NUM_DOMAINS-1:0] w_acks;
   logic                   w_ack_cur;
   logic                   w_req;
   logic [NUM_DOMAINS-1:0] w_de_mask;
   logic [NUM_DOMAINS-1:0] w_rst_out;
   logic [NUM_DOMAINS-1:0] w_de_out;
   logic                   w_rdy_out;

   logic [NUM_DOMAINS-1:0] r_dom_rst;
   logic [NUM_DOMAINS-1:0] r_dom_de;
   logic                   r_rdy;
   logic                   r_err;

   // Saturating decrement: counters never wrap below zero.
   function automatic logic [7:0] dec8(input logic [7:0] v);
      return (v == 8'd0) ? 8'd0 : v - 8'd1;
   endfunction

   // Two-flop synchronizers; reset to "no external request, all domains in reset".
   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) begin
         r_sync1 <= '1;
         r_sync2 <= '1;
      end else begin
         r_sync1 <= {ext_rst_n, dom_rst_ack};
         r_sync2 <= r_sync1;
      end
   end

   assign w_acks    = r_sync2[NUM_DOMAINS-1:0];
   assign w_ack_cur = w_acks[r_idx];
   assign w_req     = sw_rst_req | ~r_sync2[NUM_DOMAINS];

   // State, shared counter and domain index registers.
   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) begin
         r_state <= ST_ASSERT;
         r_cnt   <= HOLD_LD;
         r_idx   <= '0;
      end else begin
         r_state <= w_nxt_state;
         r_cnt   <= w_nxt_cnt;
         r_idx   <= w_nxt_idx;
      end
   end

   // Next-state logic; the single counter is reused as hold, timeout and gap
   // counter and is reloaded on every transition that needs it.
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_cnt   = r_cnt;
      w_nxt_idx   = r_idx;
      w_set_err   = 1'b0;
      case (r_state)
         ST_ASSERT: begin
            if (r_cnt == 8'd0) w_nxt_state = ST_RELEASE;
            else               w_nxt_cnt   = dec8(r_cnt);
         end
         ST_RELEASE: begin
            w_nxt_idx   = '0;
            w_nxt_cnt   = TMO_LD;
            w_nxt_state = ST_WAITACK;
         end
         ST_WAITACK: begin
            // Counter would reach zero this cycle -> timeout, unless the ack
            // arrived at the same time, which wins.
            if (!w_ack_cur || (r_cnt <= 8'd1)) begin
               w_set_err = w_ack_cur;
               if (r_idx == LAST_IDX) begin
                  w_nxt_state = ST_DONE;
               end else begin
                  w_nxt_state = ST_GAP;
                  w_nxt_cnt   = GAP_LD;
               end
            end else begin
               w_nxt_cnt = dec8(r_cnt);
            end
         end
         ST_GAP: begin
            if (r_cnt == 8'd0) begin
               w_nxt_idx   = r_idx + IW'(1);
               w_nxt_cnt   = TMO_LD;
               w_nxt_state = ST_WAITACK;
            end else begin
               w_nxt_cnt = dec8(r_cnt);
            end
         end
         ST_DONE: begin
            w_nxt_state = ST_DONE;
         end
         default: begin
            w_nxt_state = ST_ASSERT;
            w_nxt_cnt   = HOLD_LD;
            w_nxt_idx   = '0;
         end
      endcase
      // Any reset request overrides the sequence and restarts the full hold.
      if (w_req) begin
         w_nxt_state = ST_ASSERT;
         w_nxt_cnt   = HOLD_LD;
         w_nxt_idx   = '0;
         w_set_err   = 1'b0;
      end
   end

   // Thermometer mask: current domain and all lower ones are released.
   always_comb begin
      w_de_mask = '0;
      for (int i = 0; i < NUM_DOMAINS; i++) begin
         w_de_mask[i] = (i <= int'(r_idx));
      end
   end

   // Output decode from the current state; registered below.
   always_comb begin
      w_rst_out = '0;
      w_de_out  = '0;
      w_rdy_out = 1'b0;
      case (r_state)
         ST_ASSERT:  w_rst_out = '1;
         ST_RELEASE: w_rst_out = '0;
         ST_WAITACK: w_de_out  = w_de_mask;
         ST_GAP:     w_de_out  = w_de_mask;
         ST_DONE: begin
            w_de_out  = '1;
            w_rdy_out = 1'b1;
         end
         default:    w_rst_out = '1;
      endcase
   end

   // Registered domain controls and ready flag.
   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) begin
         r_dom_rst <= '1;
         r_dom_de  <= '0;
         r_rdy     <= 1'b0;
      end else begin
         r_dom_rst <= w_rst_out;
         r_dom_de  <= w_de_out;
         r_rdy     <= w_rdy_out;
      end
   end

   // Sticky timeout flag, cleared whenever the FSM heads into Assert.
   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async)                     r_err <= 1'b0;
      else if (w_nxt_state == ST_ASSERT) r_err <= 1'b0;
      else if (w_set_err)                r_err <= 1'b1;
   end

   assign dom_rst_async = r_dom_rst;
   assign dom_deassert  = r_dom_de;
   assign all_ready     = r_rdy;
   assign seq_error     = r_err;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: directed scenarios push the expected output
// changes (cycle stamp + output vector) into a queue; a monitor pops one
// entry every time the output vector changes and compares both.
module tb_rst_seq_ctrl;

   logic       clk;
   logic       rst_async;
   logic       ext_rst_n;
   logic       sw_rst_req;
   logic [3:0] dom_rst_ack;
   logic [3:0] dom_rst_async;
   logic [3:0] dom_deassert;
   logic       all_ready;
   logic       seq_error;

   rst_seq_ctrl dut (
      .clk           (clk),
      .rst_async     (rst_async),
      .ext_rst_n     (ext_rst_n),
      .sw_rst_req    (sw_rst_req),
      .dom_rst_ack   (dom_rst_ack),
      .dom_rst_async (dom_rst_async),
      .dom_deassert  (dom_deassert),
      .all_ready     (all_ready),
      .seq_error     (seq_error)
   );

   // Output vector: {dom_rst_async, dom_deassert, all_ready, seq_error}
   logic [9:0] vec;
   assign vec = {dom_rst_async, dom_deassert, all_ready, seq_error};

   localparam logic [9:0] RSTV = {4'hF, 4'h0, 1'b0, 1'b0};

   typedef struct {
      int         stamp;
      logic [9:0] v;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   gcyc  = 0;

   logic [3:0] stuck;
   int         dly[4];
   int         dcnt[4];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) gcyc <= gcyc + 1;

   function automatic logic [9:0] mk(input logic [3:0] r, input logic [3:0] d,
                                     input logic rdy, input logic err);
      return {r, d, rdy, err};
   endfunction

   task automatic push(input int st, input logic [9:0] v);
      exp_t e;
      e.stamp = st;
      e.v     = v;
      q.push_back(e);
   endtask

   task automatic check(input string nm, input logic [9:0] got, input logic [9:0] req);
      n_cmp++;
      if (got !== req) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", nm, got, req);
      end
   endtask

   // Standard full sequence with every ack dropping 3 cycles after release.
   task automatic push_std(input int b);
      push(b + 17, mk(4'h0, 4'h0, 1'b0, 1'b0));
      push(b + 18, mk(4'h0, 4'h1, 1'b0, 1'b0));
      push(b + 32, mk(4'h0, 4'h3, 1'b0, 1'b0));
      push(b + 46, mk(4'h0, 4'h7, 1'b0, 1'b0));
      push(b + 60, mk(4'h0, 4'hF, 1'b0, 1'b0));
      push(b + 66, mk(4'h0, 4'hF, 1'b1, 1'b0));
   endtask

   task automatic wait_drain(input string nm, input int lim);
      int n;
      n = 0;
      while (q.size() != 0 && n < lim) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s_timeout: %0d events pending after %0d cycles, required 0",
                  nm, q.size(), lim);
         q.delete();
      end
      repeat (8) @(negedge clk);
   endtask

   // Mid-cycle asynchronous reset pulse; outputs must drop immediately.
   task automatic apply_rst();
      @(posedge clk);
      #2 rst_async = 1'b1;
      push(gcyc, RSTV);
      #1 check("async_reset", vec, RSTV);
      repeat (2) @(negedge clk);
   endtask

   task automatic release_rst(output int b);
      @(negedge clk);
      rst_async = 1'b0;
      b = gcyc;
   endtask

   // Domain model: ack high while in reset, drops dly[i] cycles after release.
   initial begin
      dom_rst_ack = '1;
      for (int i = 0; i < 4; i++) begin
         dcnt[i] = 0;
         dly[i]  = 3;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            if (dom_deassert[i] && !dom_rst_async[i]) dcnt[i] = dcnt[i] + 1;
            else                                       dcnt[i] = 0;
            dom_rst_ack[i] = stuck[i] || (dcnt[i] < dly[i]);
         end
      end
   end

   // Monitor: every output change is matched against the next expectation.
   initial begin
      logic [9:0] prev;
      exp_t       e;
      @(negedge clk);
      prev = vec;
      forever begin
         @(negedge clk);
         if (vec !== prev) begin
            n_cmp++;
            if (q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_change: got %h at cycle %0d, required no change",
                        vec, gcyc);
            end else begin
               e = q.pop_front();
               if (vec !== e.v || gcyc != e.stamp) begin
                  n_err++;
                  $display("FAIL out_change: got %h at cycle %0d, required %h at cycle %0d",
                           vec, gcyc, e.v, e.stamp);
               end
            end
            prev = vec;
         end
      end
   end

   // Stimulus
   initial begin
      int b;
      int p;
      int x;
      rst_async  = 1'b0;
      ext_rst_n  = 1'b1;
      sw_rst_req = 1'b0;
      stuck      = 4'h0;
      #1 rst_async = 1'b1;
      @(negedge clk);
      check("reset_state", vec, RSTV);
      repeat (2) @(negedge clk);

      // Default sequence out of power-on reset
      release_rst(b);
      push_std(b);
      wait_drain("seq_default", 400);

      // Reset from Done, domain 2 ack stuck high -> timeout, domain 3 still released
      apply_rst();
      stuck[2] = 1'b1;
      release_rst(b);
      push(b + 17,  mk(4'h0, 4'h0, 1'b0, 1'b0));
      push(b + 18,  mk(4'h0, 4'h1, 1'b0, 1'b0));
      push(b + 32,  mk(4'h0, 4'h3, 1'b0, 1'b0));
      push(b + 46,  mk(4'h0, 4'h7, 1'b0, 1'b0));
      push(b + 300, mk(4'h0, 4'h7, 1'b0, 1'b1));
      push(b + 309, mk(4'h0, 4'hF, 1'b0, 1'b1));
      push(b + 315, mk(4'h0, 4'hF, 1'b1, 1'b1));
      wait_drain("seq_stuck", 400);
      stuck[2] = 1'b0;

      // Software request from Done clears seq_error; second request lands in
      // the gap after domain 1 and restarts the full hold
      @(negedge clk);
      sw_rst_req = 1'b1;
      p = gcyc + 1;
      push(p,      mk(4'h0, 4'hF, 1'b1, 1'b0));
      push(p + 1,  RSTV);
      push(p + 17, mk(4'h0, 4'h0, 1'b0, 1'b0));
      push(p + 18, mk(4'h0, 4'h1, 1'b0, 1'b0));
      push(p + 32, mk(4'h0, 4'h3, 1'b0, 1'b0));
      @(negedge clk);
      sw_rst_req = 1'b0;
      while (gcyc < p + 39) @(negedge clk);
      sw_rst_req = 1'b1;
      p = gcyc + 1;
      push(p + 1, RSTV);
      push_std(p);
      @(negedge clk);
      sw_rst_req = 1'b0;
      wait_drain("seq_sw_gap", 400);

      // Push-button reset held low for 40 cycles
      @(negedge clk);
      ext_rst_n = 1'b0;
      x = gcyc;
      push(x + 4, RSTV);
      repeat (40) @(negedge clk);
      ext_rst_n = 1'b1;
      push_std(x + 42);
      wait_drain("seq_ext", 400);

      // Domain 0 ack arrives on the very cycle its timeout expires
      apply_rst();
      dly[0] = 252;
      release_rst(b);
      push(b + 17,  mk(4'h0, 4'h0, 1'b0, 1'b0));
      push(b + 18,  mk(4'h0, 4'h1, 1'b0, 1'b0));
      push(b + 281, mk(4'h0, 4'h3, 1'b0, 1'b0));
      push(b + 295, mk(4'h0, 4'h7, 1'b0, 1'b0));
      push(b + 309, mk(4'h0, 4'hF, 1'b0, 1'b0));
      push(b + 315, mk(4'h0, 4'hF, 1'b1, 1'b0));
      wait_drain("seq_ack_tmo", 400);
      dly[0] = 3;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
